// File: rtl/sobel_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : sobel_edge_detector
// Brief    : Streaming 3x3 Sobel edge detector on RGB444 pixels. Converts to
//            4-bit grayscale, buffers two lines, forms a 3x3 window and flags
//            |Gx|+|Gy| > THRESHOLD at the window centre (x_reg-1, y_reg-1).
//            Optional macro SOBEL_OUTPUT_REG_EN registers the result
//            (one extra clk of latency); otherwise result is combinational.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_edge_detector #(
  parameter int IMG_WIDTH = 640,
  parameter int THRESHOLD = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic [11:0] data,
  output logic        result
);

  localparam int          ADDR_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [10:0] C_WIDTH  = 11'(IMG_WIDTH);
  localparam logic [7:0]  C_THRESH = 8'(THRESHOLD);

  // Line memories: line0 = previous row, line1 = row before that
  logic [3:0] r_line0 [IMG_WIDTH];
  logic [3:0] r_line1 [IMG_WIDTH];

  // Window registers, r_pRC = row R (0 = top), column C (0 = oldest)
  logic [3:0] r_p00, r_p01, r_p02;
  logic [3:0] r_p10, r_p11, r_p12;
  logic [3:0] r_p20, r_p21, r_p22;
  logic [9:0] r_x, r_y;

  logic [5:0]        w_sum;
  logic [3:0]        w_gray;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_top, w_mid;
  logic [7:0]        w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic [7:0]        w_gx, w_gy, w_abs_gx, w_abs_gy, w_mag;
  logic              w_edge;

  // Grayscale (R + 2G + B) >> 2 and line-memory addressing
  always_comb begin
    w_sum     = {2'b00, data[11:8]} + {1'b0, data[7:4], 1'b0} + {2'b00, data[3:0]};
    w_gray    = w_sum[5:2];
    w_addr_ok = ({1'b0, x_pixel} < C_WIDTH);
    w_addr    = x_pixel[ADDR_W-1:0];
    w_top     = w_addr_ok ? r_line1[w_addr] : 4'd0;
    w_mid     = w_addr_ok ? r_line0[w_addr] : 4'd0;
  end

  // Line memories are not reset; border masking hides stale rows
  always_ff @(posedge clk) begin
    if (w_addr_ok) begin
      r_line1[w_addr] <= r_line0[w_addr];
      r_line0[w_addr] <= w_gray;
    end
  end

  // Window shift and coordinate registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p00 <= '0; r_p01 <= '0; r_p02 <= '0;
      r_p10 <= '0; r_p11 <= '0; r_p12 <= '0;
      r_p20 <= '0; r_p21 <= '0; r_p22 <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      r_p00 <= r_p01; r_p01 <= r_p02; r_p02 <= w_top;
      r_p10 <= r_p11; r_p11 <= r_p12; r_p12 <= w_mid;
      r_p20 <= r_p21; r_p21 <= r_p22; r_p22 <= w_gray;
      r_x   <= x_pixel;
      r_y   <= y_pixel;
    end
  end

  // Sobel gradients, magnitude, threshold and border mask
  always_comb begin
    w_gx_pos = {4'd0, r_p02} + {3'd0, r_p12, 1'b0} + {4'd0, r_p22};
    w_gx_neg = {4'd0, r_p00} + {3'd0, r_p10, 1'b0} + {4'd0, r_p20};
    w_gy_pos = {4'd0, r_p20} + {3'd0, r_p21, 1'b0} + {4'd0, r_p22};
    w_gy_neg = {4'd0, r_p00} + {3'd0, r_p01, 1'b0} + {4'd0, r_p02};
    // Two's-complement differences; range +/-60 fits in 8 bits
    w_gx     = w_gx_pos - w_gx_neg;
    w_gy     = w_gy_pos - w_gy_neg;
    w_abs_gx = w_gx[7] ? (8'd0 - w_gx) : w_gx;
    w_abs_gy = w_gy[7] ? (8'd0 - w_gy) : w_gy;
    w_mag    = w_abs_gx + w_abs_gy;
    // Masking the first two columns also hides row-wrap windows
    w_edge   = (w_mag > C_THRESH) && (r_x >= 10'd2) && (r_y >= 10'd2);
  end

`ifdef SOBEL_OUTPUT_REG_EN
  logic r_result;

  // Registered result, one extra clk of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_result <= 1'b0;
    else          r_result <= w_edge;
  end

  assign result = r_result;
`else
  assign result = w_edge;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_edge_detector
// Brief    : Directed self-checking bench for sobel_edge_detector. Expected
//            results are hand-derived per pattern (step position / row).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_edge_detector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  x_pixel = '0;
  logic [9:0]  y_pixel = '0;
  logic [11:0] data = '0;
  logic        result;

  int n_vec = 0;
  int n_err = 0;
  logic exp_prev = 1'b0;

  sobel_edge_detector dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x_pixel (x_pixel),
    .y_pixel (y_pixel),
    .data    (data),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Compare result with the expectation for the pixel just clocked in
  task automatic check(input logic exp, input string tag);
    logic req;
`ifdef SOBEL_OUTPUT_REG_EN
    req = exp_prev;
`else
    req = exp;
`endif
    exp_prev = exp;
    n_vec++;
    assert (result === req) else begin
      n_err++;
      $error("FAIL %s x=%0d y=%0d: result=%0b expected=%0b", tag, x_pixel, y_pixel, result, req);
    end
  endtask

  // Present one pixel, clock it in, sample 1 time unit after the edge
  task automatic px(input int x, input int y, input logic [11:0] d);
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    data    = d;
    @(posedge clk);
    #1;
  endtask

  // Vertical step at column sx; edge expected at x_reg = sx, sx+1 on rows >= 2
  task automatic run_vstep(input int sx, input logic [11:0] lo, input logic [11:0] hi,
                           input int rows, input int width, input logic hit, input string tag);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < width; x++) begin
        px(x, y, (x < sx) ? lo : hi);
        check((y >= 2 && (x == sx || x == sx + 1)) ? hit : 1'b0, tag);
      end
    end
  endtask

  // Horizontal step at row sy; edge expected on rows sy, sy+1 for x_reg >= 2
  task automatic run_hstep(input int sy, input int rows, input int width, input string tag);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < width; x++) begin
        px(x, y, (y < sy) ? 12'h000 : 12'hFFF);
        check(((y == sy || y == sy + 1) && x >= 2) ? 1'b1 : 1'b0, tag);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check(1'b0, "reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    exp_prev = 1'b0;

    // Uniform white frame: never an edge
    run_vstep(8, 12'hFFF, 12'hFFF, 4, 16, 1'b0, "uniform");

    // Full-strength vertical step at x=320 (Gx = 60)
    run_vstep(320, 12'h000, 12'hFFF, 5, 336, 1'b1, "vstep320");

    // Low-contrast step, gray 0->1, magnitude 4
    run_vstep(8, 12'h000, 12'h111, 4, 16, 1'b0, "lowcontrast");

    // Threshold boundary and grayscale weighting: magnitude = 4 * gray
    run_vstep(8, 12'h000, 12'h555, 3, 16, 1'b0, "mag20");   // gray 5 -> 20, not > 20
    run_vstep(8, 12'h000, 12'h666, 3, 16, 1'b1, "mag24");   // gray 6 -> 24
    run_vstep(8, 12'h000, 12'hF00, 3, 16, 1'b0, "red_only"); // gray 3 -> 12
    run_vstep(8, 12'h000, 12'h0F0, 3, 16, 1'b1, "green_only"); // gray 7 -> 28
    run_vstep(8, 12'h000, 12'h00F, 3, 16, 1'b0, "blue_only"); // gray 3 -> 12
    run_vstep(8, 12'hFFF, 12'h000, 3, 16, 1'b1, "neg_step"); // Gx = -60

    // Horizontal step at row 100 (Gy = 60)
    run_hstep(100, 103, 16, "hstep100");

    // Mid-frame reset while an edge is flagged
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 16; x++) begin
        px(x, y, (x < 8) ? 12'h000 : 12'hFFF);
        check(1'b0, "pre_reset");
      end
    for (int x = 0; x < 10; x++) begin
      px(x, 2, (x < 8) ? 12'h000 : 12'hFFF);
      check((x == 8 || x == 9) ? 1'b1 : 1'b0, "pre_reset_row2");
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    assert (result === 1'b0) else begin
      n_err++;
      $error("FAIL async_reset: result=%0b expected=0", result);
    end
    @(posedge clk);
    #1;
    n_vec++;
    assert (result === 1'b0) else begin
      n_err++;
      $error("FAIL held_reset: result=%0b expected=0", result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_prev = 1'b0;
    // Memories still hold the step; rows 0 and 1 must stay masked
    run_vstep(8, 12'h000, 12'hFFF, 3, 16, 1'b1, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on simulation time
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sobel_edge_detector.md
SOBEL_EDGE_DETECTOR -- requirements
Module: sobel_edge_detector

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line; sets line-memory depth.
REQ-002 Parameter THRESHOLD, default 20, unsigned 8-bit edge threshold compared against gradient magnitude.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 x_pixel  input  10  column of the pixel presented on data, 0..IMG_WIDTH-1.
REQ-006 y_pixel  input  10  row of the pixel presented on data.
REQ-007 data  input  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}, sampled every rising edge of clk.
REQ-008 result  output  1  1 = edge at window centre, 0 = no edge.

Function
REQ-009 Grayscale: gray = (R + 2*G + B) >> 2, a 4-bit unsigned value 0..15, computed combinationally from data.
REQ-010 Line memories: two IMG_WIDTH x 4-bit memories, L0 holds the previous row and L1 holds the row before it, both indexed by x_pixel.
REQ-011 On each clk edge, L1[x_pixel] SHALL take the old L0[x_pixel] and L0[x_pixel] SHALL take the current gray (read-before-write).
REQ-012 3x3 window registers: on each clk edge, column 0 SHALL take column 1, column 1 SHALL take column 2, and column 2 SHALL take {top=L1[x], mid=L0[x], bottom=gray}.
REQ-013 x_pixel and y_pixel SHALL be registered alongside the window; the window centre corresponds to pixel (x_reg-1, y_reg-1).
REQ-014 Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20), where pRC is the window pixel at row R and column C; Gx SHALL be computed as 8-bit signed (range ±60).
REQ-015 Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02), 8-bit signed.
REQ-016 Magnitude = |Gx| + |Gy|, 8-bit unsigned (max 120, no overflow).
REQ-017 result = (magnitude > THRESHOLD), strictly greater than.
REQ-018 result SHALL be derived combinationally from the window registers: valid after the clk edge that samples the pixel at (x, y), for centre (x-1, y-1).
REQ-019 Border masking: result SHALL be 0 whenever x_reg < 2 or y_reg < 2, which covers both the first two rows and the row-wrap columns.
REQ-020 x_pixel and y_pixel are trusted to be in range; behaviour for x_pixel >= IMG_WIDTH is don't-care, and memory writes SHALL be suppressed in that case.
REQ-021 Pixels are streamed continuously with no stall or valid handshake; every clk edge consumes one pixel.

Reset
REQ-022 While reset_n = 0, all window registers, x_reg and y_reg SHALL clear to 0, and result SHALL be 0 immediately (asynchronously).
REQ-023 Line memories SHALL NOT be reset; stale contents are hidden by REQ-019 for the first two rows after reset.
REQ-024 A reset asserted mid-frame SHALL take effect immediately; after release, processing restarts with whatever coordinates are presented.

Configuration
REQ-025 Macro SOBEL_OUTPUT_REG_EN: when defined, result SHALL be registered (reset to 0), adding exactly one clk of latency, with masking applied before the register.
REQ-026 When SOBEL_OUTPUT_REG_EN is not defined, result SHALL be combinational per REQ-018.

Verification
REQ-027 Uniform frame, all pixels 0xFFF -> result = 0 for every pixel.
REQ-028 Vertical step, 0x000 for x < 320 and 0xFFF for x >= 320 -> for y_reg >= 2, result = 1 exactly at x_reg = 320 and 321 (Gx = 60), and 0 elsewhere.
REQ-029 Low-contrast step, 0x000 to 0x111 (gray 0 to 1, magnitude 4) -> result = 0 everywhere.
REQ-030 Horizontal step at row 100, 0x000 above and 0xFFF from row 100 -> result = 1 for y_reg = 100 and 101 with x_reg >= 2, and 0 for rows 0 and 1 regardless of memory contents.
REQ-031 Assert reset_n = 0 mid-frame while result = 1 -> result = 0 in the same cycle; the first two rows after release are masked to 0.
REQ-032 With SOBEL_OUTPUT_REG_EN defined, repeat REQ-028 -> identical pattern, delayed by exactly one clk.
